// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MDU_OP_MULT  = 3'd0;
    localparam logic [2:0] MDU_OP_MULTU = 3'd1;
    localparam logic [2:0] MDU_OP_DIV   = 3'd2;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, try the subtract.
module mdu_div_step (
    input  logic [31:0] rem_i,
    input  logic        dividend_bit_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic        q_o
);
    logic [32:0] shifted;

    assign shifted = {rem_i, dividend_bit_i};
    assign q_o     = (shifted >= {1'b0, divisor_i});
    // The restored remainder is always below the divisor, so 32 bits hold it exactly.
    assign rem_o   = q_o ? (shifted[31:0] - divisor_i) : shifted[31:0];

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers.
// Define MDU_FAST_MUL_EN to run MULT/MULTU as a single-cycle multiply.
module mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    mdu_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        load_q, load_d;
    logic        is_div_q, is_div_d;
    logic        fast_q, fast_d;
    logic        s1_q, s1_d, s2_q, s2_d;
    logic [31:0] m1_q, m1_d, m2_q, m2_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;

    logic        accept, accept_fast;
    logic [31:0] rem_next;
    logic        q_bit;
    logic [32:0] mul_sum;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, op1_fix;

    assign accept = (state_q == ST_IDLE) && start && is_muldiv(op);
`ifdef MDU_FAST_MUL_EN
    assign accept_fast = accept && !is_div_op(op);
`else
    assign accept_fast = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; the first CALC cycle only loads the accumulator
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = accept_fast ? ST_FIX : ST_CALC;
            ST_CALC: if (!load_q && (cnt_q == 5'd31)) state_d = ST_FIX;
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != ST_IDLE) && !fast_q;
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

    mdu_div_step u_div_step (
        .rem_i          (acc_q[63:32]),
        .dividend_bit_i (acc_q[31]),
        .divisor_i      (m2_q),
        .rem_o          (rem_next),
        .q_o            (q_bit)
    );

    // Shift-add: acc holds {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m1_q} : 33'd0);
    assign prod_fix = (s1_q ^ s2_q) ? (64'd0 - acc_q) : acc_q;
    assign quo_fix  = (s1_q ^ s2_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem_fix  = s1_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    assign op1_fix  = s1_q ? (32'd0 - m1_q) : m1_q;

    always_comb begin
        cnt_d    = cnt_q;
        load_d   = load_q;
        is_div_d = is_div_q;
        fast_d   = fast_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        m1_d     = m1_q;
        m2_d     = m2_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    s1_d     = is_signed_op(op) & operand1[31];
                    s2_d     = is_signed_op(op) & operand2[31];
                    m1_d     = s1_d ? (32'd0 - operand1) : operand1;
                    m2_d     = s2_d ? (32'd0 - operand2) : operand2;
                    is_div_d = is_div_op(op);
                    cnt_d    = 5'd0;
                    load_d   = 1'b1;
                    fast_d   = accept_fast;
`ifdef MDU_FAST_MUL_EN
                    if (accept_fast) acc_d = {32'd0, m1_d} * {32'd0, m2_d};
`endif
                end else if (start && (op == MDU_OP_MTHI)) begin
                    hi_d = operand1;
                end else if (start && (op == MDU_OP_MTLO)) begin
                    lo_d = operand1;
                end
            end
            ST_CALC: begin
                if (load_q) begin
                    load_d = 1'b0;
                    acc_d  = {32'd0, (is_div_q ? m1_q : m2_q)};
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    if (is_div_q) acc_d = {rem_next, acc_q[30:0], q_bit};
                    else          acc_d = {mul_sum, acc_q[31:1]};
                end
            end
            ST_FIX: begin
                done_d = 1'b1;
                fast_d = 1'b0;
                if (is_div_q) begin
                    if (m2_q == 32'd0) begin
                        hi_d = op1_fix;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 5'd0;
            load_q   <= 1'b0;
            is_div_q <= 1'b0;
            fast_q   <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            m1_q     <= 32'd0;
            m2_q     <= 32'd0;
            acc_q    <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            is_div_q <= is_div_d;
            fast_q   <= fast_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            m1_q     <= m1_d;
            m2_q     <= m2_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu (default and MDU_FAST_MUL_EN builds).
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_LAT  = 34;
    localparam int MUL_BUSY = 34;
`endif

    mdu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .operand1 (operand1),
        .operand2 (operand2),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        op       = o;
        operand1 = a;
        operand2 = b;
        tick();
        start    = 1'b0;
        op       = 3'd7;
        operand1 = 32'd0;
        operand2 = 32'd0;
    endtask

    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 3'd7; operand1 = 32'd0; operand2 = 32'd0;
        tick(); tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
        $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    endtask

    task automatic test_multu();
        int lat, bc;
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        checks++; if (lat !== MUL_LAT) begin failures++; $display("FAIL multu_latency: got %0d expected %0d", lat, MUL_LAT); end
        checks++; if (bc !== MUL_BUSY) begin failures++; $display("FAIL multu_busy_cycles: got %0d expected %0d", bc, MUL_BUSY); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        $display("MULTU ffffffff*ffffffff: hi=%h lo=%h lat=%0d busy=%0d", hi, lo, lat, bc);
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_mult_signed();
        int lat, bc;
        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        wait_done(lat, bc);
        checks++; if (lat !== MUL_LAT) begin failures++; $display("FAIL mult_latency: got %0d expected %0d", lat, MUL_LAT); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
        $display("MULT -3*5: hi=%h lo=%h lat=%0d", hi, lo, lat);
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bc);
        checks++; if (lat !== 34) begin failures++; $display("FAIL div_latency: got %0d expected 34", lat); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
        $display("DIV -7/2: hi=%h lo=%h lat=%0d", hi, lo, lat);
        issue(3'd3, 32'd100, 32'd7);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy: got %b expected 1", busy); end
        wait_done(lat, bc);
        checks++; if (lat !== 34) begin failures++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL b2b_lo: got %h expected 0000000e", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL b2b_hi: got %h expected 00000002", hi); end
        $display("DIVU 100/7: hi=%h lo=%h lat=%0d", hi, lo, lat);
    endtask

    task automatic test_div_boundary();
        int lat, bc;
        issue(3'd3, 32'h64, 32'd0);
        wait_done(lat, bc);
        checks++; if (hi !== 32'h64) begin failures++; $display("FAIL divu0_hi: got %h expected 00000064", hi); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu0_lo: got %h expected ffffffff", lo); end
        $display("DIVU 64/0: hi=%h lo=%h", hi, lo);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL divovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL divovf_hi: got %h expected 00000000", hi); end
        $display("DIV 80000000/ffffffff: hi=%h lo=%h", hi, lo);
        issue(3'd2, 32'hFFFF_FFFB, 32'd0);
        wait_done(lat, bc);
        checks++; if (hi !== 32'hFFFF_FFFB) begin failures++; $display("FAIL div0_hi: got %h expected fffffffb", hi); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_lo: got %h expected ffffffff", lo); end
        $display("DIV -5/0: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_mthi_mtlo();
        issue(3'd4, 32'hA5A5_A5A5, 32'd0);
        checks++; if (hi !== 32'hA5A5_A5A5) begin failures++; $display("FAIL mthi_hi: got %h expected a5a5a5a5", hi); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL mthi_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy: got %b expected 0", busy); end
        $display("MTHI a5a5a5a5: hi=%h done=%b", hi, done);
        issue(3'd5, 32'h0000_1234, 32'd0);
        checks++; if (lo !== 32'h0000_1234) begin failures++; $display("FAIL mtlo_lo: got %h expected 00001234", lo); end
        checks++; if (hi !== 32'hA5A5_A5A5) begin failures++; $display("FAIL mtlo_hi_kept: got %h expected a5a5a5a5", hi); end
        $display("MTLO 00001234: lo=%h", lo);
    endtask

    task automatic test_ignore_busy();
        int lat, bc;
        issue(3'd3, 32'd200, 32'd9);
        for (int i = 0; i < 4; i++) tick();
        issue(3'd5, 32'hDEAD_BEEF, 32'd0);
        checks++; if (lo !== 32'h0000_1234) begin failures++; $display("FAIL ignore_mtlo_lo: got %h expected 00001234", lo); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy: got %b expected 1", busy); end
        wait_done(lat, bc);
        checks++; if (lat !== 29) begin failures++; $display("FAIL ignore_latency: got %0d expected 29", lat); end
        checks++; if (lo !== 32'd22) begin failures++; $display("FAIL ignore_lo: got %h expected 00000016", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL ignore_hi: got %h expected 00000002", hi); end
        $display("DIVU 200/9 with MTLO while busy: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_reset_mid();
`ifdef MDU_FAST_MUL_EN
        issue(3'd3, 32'd1000, 32'd3);
`else
        issue(3'd0, 32'd7, 32'd9);
`endif
        for (int i = 0; i < 9; i++) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL rstmid_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL rstmid_lo: got %h expected 00000000", lo); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_after_busy: got %b expected 0", busy); end
        $display("reset mid-op: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    endtask

    task automatic test_fast_mul();
        int lat, bc;
        issue(3'd1, 32'd6, 32'd7);
        wait_done(lat, bc);
        checks++; if (lat !== MUL_LAT) begin failures++; $display("FAIL fast_latency: got %0d expected %0d", lat, MUL_LAT); end
        checks++; if (bc !== MUL_BUSY) begin failures++; $display("FAIL fast_busy_cycles: got %0d expected %0d", bc, MUL_BUSY); end
        checks++; if (lo !== 32'd42) begin failures++; $display("FAIL fast_lo: got %h expected 0000002a", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL fast_hi: got %h expected 00000000", hi); end
        $display("MULTU 6*7: hi=%h lo=%h lat=%0d busy=%0d", hi, lo, lat, bc);
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult_signed();
        test_back_to_back();
        test_div_boundary();
        test_mthi_mtlo();
        test_ignore_busy();
        test_reset_mid();
        test_fast_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
